// File: rtl/i2cmb_env_pkg.sv
// Shared definitions for the I2CMB command sequencer: register map, CMDR codes and bits,
// response status codes, sequencer states and the CMDR status decode.
// No ports; imported by i2cmb_wb_xfer and i2cmb_cmd_sequencer.
package i2cmb_env_pkg;

  // I2CMB register map
  localparam logic [1:0] CSR_ADDR  = 2'd0;
  localparam logic [1:0] DPR_ADDR  = 2'd1;
  localparam logic [1:0] CMDR_ADDR = 2'd2;
  localparam logic [1:0] FSMR_ADDR = 2'd3;

  // CSR: core enable (E) + interrupt enable (IE)
  localparam logic [7:0] CSR_ENABLE_VAL = 8'hC0;

  // CMDR status bit positions
  localparam int CMDR_DON = 7;
  localparam int CMDR_NAK = 6;
  localparam int CMDR_AL  = 5;
  localparam int CMDR_ERR = 4;
  localparam int CMDR_R   = 3;

  typedef enum logic [2:0] {
    OP_NONE     = 3'b000,
    OP_WRITE    = 3'b001,
    OP_READ_ACK = 3'b010,
    OP_READ_NAK = 3'b011,
    OP_START    = 3'b100,
    OP_STOP     = 3'b101,
    OP_SET_BUS  = 3'b110,
    OP_RSVD     = 3'b111
  } i2c_op_t;

  typedef enum logic [2:0] {
    STAT_DONE     = 3'd0,
    STAT_NAK      = 3'd1,
    STAT_ARB_LOST = 3'd2,
    STAT_ERR      = 3'd3,
    STAT_TIMEOUT  = 3'd4,
    STAT_BAD_OP   = 3'd5
  } seq_status_t;

  typedef enum logic [2:0] {
    S_EN_CORE,
    S_IDLE,
    S_WR_DPR,
    S_WR_CMDR,
    S_WAIT_IRQ,
    S_RD_CMDR,
    S_RD_DPR,
    S_RESP
  } seq_state_t;

  // Error-type bits win over completion; a CMDR with no status bit at all is
  // treated as an error since the IRQ should only fire with one of them set.
  function automatic seq_status_t decode_cmdr(input logic [7:0] v);
    if (v[CMDR_ERR] || v[CMDR_R]) return STAT_ERR;
    else if (v[CMDR_AL])          return STAT_ARB_LOST;
    else if (v[CMDR_NAK])         return STAT_NAK;
    else if (v[CMDR_DON])         return STAT_DONE;
    else                          return STAT_ERR;
  endfunction

endpackage

// File: rtl/i2cmb_wb_xfer.sv
// Single-access Wishbone master: one registered read or write per request.
// Ports: req_i/we_i/adr_i/wdata_i request; done_o (ack cycle) with rdata_o; cyc/stb/we/adr/dat bus.
// Latency: bus asserted the cycle after req_i is sampled; done_o in the ack cycle. Requests are
// ignored while an access is in flight or finishing, which forces one idle cycle between accesses.
module i2cmb_wb_xfer #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] adr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  cyc_o,
  output logic                  stb_o,
  output logic                  we_o,
  output logic [ADDR_WIDTH-1:0] adr_o,
  output logic [DATA_WIDTH-1:0] dat_o,
  input  logic [DATA_WIDTH-1:0] dat_i,
  input  logic                  ack_i
);

  logic                  cyc_q, cyc_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [DATA_WIDTH-1:0] dat_q, dat_d;

  always_comb begin
    cyc_d = cyc_q;
    we_d  = we_q;
    adr_d = adr_q;
    dat_d = dat_q;
    if (cyc_q) begin
      // Hold everything stable until ack; then return the bus to all-zero.
      if (ack_i) begin
        cyc_d = 1'b0;
        we_d  = 1'b0;
        adr_d = '0;
        dat_d = '0;
      end
    end else if (req_i) begin
      cyc_d = 1'b1;
      we_d  = we_i;
      adr_d = adr_i;
      dat_d = we_i ? wdata_i : '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cyc_q <= 1'b0;
      we_q  <= 1'b0;
      adr_q <= '0;
      dat_q <= '0;
    end else begin
      cyc_q <= cyc_d;
      we_q  <= we_d;
      adr_q <= adr_d;
      dat_q <= dat_d;
    end
  end

  assign cyc_o   = cyc_q;
  assign stb_o   = cyc_q;
  assign we_o    = we_q;
  assign adr_o   = adr_q;
  assign dat_o   = dat_q;
  assign done_o  = cyc_q & ack_i;
  assign rdata_o = dat_i;

endmodule

// File: rtl/i2cmb_cmd_sequencer.sv
// Wishbone master that enables the I2CMB core, then runs one byte-level I2C command at a time
// (DPR write, CMDR write, IRQ wait, CMDR read, DPR read) and returns a decoded status + read byte.
// Ports: cmd_valid_i/cmd_ready_o/cmd_op_i/cmd_data_i command in; rsp_valid_o pulse with
// rsp_status_o/rsp_data_o; cyc/stb/we/adr/dat/ack Wishbone master; irq_i from the core.
// Latency (zero-wait slave, immediate IRQ, counting the acceptance cycle): START/STOP 5,
// WRITE/SET_BUS 7, READ_* 7, bad opcode 2. cmd_ready_o only in IDLE; client holds cmd_valid_i.
module i2cmb_cmd_sequencer
  import i2cmb_env_pkg::*;
#(
  parameter int ADDR_WIDTH  = 2,
  parameter int DATA_WIDTH  = 8,
  parameter int IRQ_TIMEOUT = 4096
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [2:0]            cmd_op_i,
  input  logic [DATA_WIDTH-1:0] cmd_data_i,
  output logic                  rsp_valid_o,
  output logic [2:0]            rsp_status_o,
  output logic [DATA_WIDTH-1:0] rsp_data_o,
  output logic                  cyc_o,
  output logic                  stb_o,
  output logic                  we_o,
  output logic [ADDR_WIDTH-1:0] adr_o,
  output logic [DATA_WIDTH-1:0] dat_o,
  input  logic [DATA_WIDTH-1:0] dat_i,
  input  logic                  ack_i,
  input  logic                  irq_i
);

  localparam int CNT_W = (IRQ_TIMEOUT > 1) ? $clog2(IRQ_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IRQ_TIMEOUT - 1);

  seq_state_t            state_q, state_d;
  i2c_op_t               op_q, op_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  seq_status_t           rsp_status_q, rsp_status_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;

  logic                  x_req, x_we, x_done;
  logic [ADDR_WIDTH-1:0] x_adr;
  logic [DATA_WIDTH-1:0] x_wdata, x_rdata;
  seq_status_t           cmdr_stat;
  logic                  op_is_read;

  assign cmdr_stat  = decode_cmdr(x_rdata[7:0]);
  assign op_is_read = (op_q == OP_READ_ACK) || (op_q == OP_READ_NAK);

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    data_d       = data_q;
    cnt_d        = cnt_q;
    rsp_status_d = rsp_status_q;
    rsp_data_d   = rsp_data_q;

    unique case (state_q)
      S_EN_CORE: if (x_done) state_d = S_IDLE;
      S_IDLE: begin
        if (cmd_valid_i) begin
          op_d   = i2c_op_t'(cmd_op_i);
          data_d = cmd_data_i;
          unique case (i2c_op_t'(cmd_op_i))
            OP_NONE, OP_RSVD: begin
              state_d      = S_RESP;
              rsp_status_d = STAT_BAD_OP;
              rsp_data_d   = '0;
            end
            OP_WRITE, OP_SET_BUS: state_d = S_WR_DPR;
            default:              state_d = S_WR_CMDR;
          endcase
        end
      end
      S_WR_DPR: if (x_done) state_d = S_WR_CMDR;
      S_WR_CMDR: begin
        if (x_done) begin
          state_d = S_WAIT_IRQ;
          cnt_d   = '0;
        end
      end
      S_WAIT_IRQ: begin
        if (irq_i) begin
          state_d = S_RD_CMDR;
        end else if (cnt_q == CNT_LAST) begin
          state_d      = S_RESP;
          rsp_status_d = STAT_TIMEOUT;
          rsp_data_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RD_CMDR: begin
        if (x_done) begin
          if (op_is_read && (cmdr_stat == STAT_DONE)) begin
            state_d = S_RD_DPR;
          end else begin
            state_d      = S_RESP;
            rsp_status_d = cmdr_stat;
            rsp_data_d   = '0;
          end
        end
      end
      S_RD_DPR: begin
        if (x_done) begin
          state_d      = S_RESP;
          rsp_status_d = STAT_DONE;
          rsp_data_d   = x_rdata;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_EN_CORE;
    endcase

    // Request the access belonging to the state being entered so the bus goes
    // up on the entry edge. If the previous access is still finishing, the
    // xfer unit drops the request and it is re-presented the next cycle.
    x_req   = 1'b0;
    x_we    = 1'b0;
    x_adr   = '0;
    x_wdata = '0;
    unique case (state_d)
      S_EN_CORE: begin
        x_req   = 1'b1;
        x_we    = 1'b1;
        x_adr   = ADDR_WIDTH'(CSR_ADDR);
        x_wdata = DATA_WIDTH'(CSR_ENABLE_VAL);
      end
      S_WR_DPR: begin
        x_req   = 1'b1;
        x_we    = 1'b1;
        x_adr   = ADDR_WIDTH'(DPR_ADDR);
        x_wdata = data_d;
      end
      S_WR_CMDR: begin
        x_req   = 1'b1;
        x_we    = 1'b1;
        x_adr   = ADDR_WIDTH'(CMDR_ADDR);
        x_wdata = DATA_WIDTH'(op_d);
      end
      S_RD_CMDR: begin
        x_req = 1'b1;
        x_adr = ADDR_WIDTH'(CMDR_ADDR);
      end
      S_RD_DPR: begin
        x_req = 1'b1;
        x_adr = ADDR_WIDTH'(DPR_ADDR);
      end
      default: x_req = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q      <= S_EN_CORE;
      op_q         <= OP_NONE;
      data_q       <= '0;
      cnt_q        <= '0;
      rsp_status_q <= STAT_DONE;
      rsp_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      data_q       <= data_d;
      cnt_q        <= cnt_d;
      rsp_status_q <= rsp_status_d;
      rsp_data_q   <= rsp_data_d;
    end
  end

  i2cmb_wb_xfer #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_xfer (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .req_i   (x_req),
    .we_i    (x_we),
    .adr_i   (x_adr),
    .wdata_i (x_wdata),
    .done_o  (x_done),
    .rdata_o (x_rdata),
    .cyc_o   (cyc_o),
    .stb_o   (stb_o),
    .we_o    (we_o),
    .adr_o   (adr_o),
    .dat_o   (dat_o),
    .dat_i   (dat_i),
    .ack_i   (ack_i)
  );

  assign cmd_ready_o  = (state_q == S_IDLE);
  assign rsp_valid_o  = (state_q == S_RESP);
  assign rsp_status_o = rsp_status_q;
  assign rsp_data_o   = rsp_data_q;

endmodule

// File: doc/i2cmb_cmd_sequencer.md
Name: i2cmb_cmd_sequencer

Overview:
- Wishbone master that sequences the I2CMB core on behalf of one command client.
- After reset it enables the core. It then accepts one byte-level I2C command at a time and performs the required register accesses: DPR write, CMDR write, IRQ wait, CMDR read to clear IRQ, and DPR read for reads.
- It returns a decoded status and any read byte.
- It sits between the test/driver layer and the I2CMB Wishbone slave, in the same position the Wishbone master agent occupies.

Parameters:
- ADDR_WIDTH, 2, Wishbone address width; register map CSR=0, DPR=1, CMDR=2, FSMR=3.
- DATA_WIDTH, 8, Wishbone data width.
- IRQ_TIMEOUT, 4096, clk_i cycles to wait for irq_i before declaring timeout.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous reset, active-low (asserted when 0)
- cmd_valid_i  in  1  command request
- cmd_ready_o  out  1  sequencer can accept a command
- cmd_op_i  in  3  I2CMB CMDR opcode: 001 WRITE, 010 READ_ACK, 011 READ_NAK, 100 START, 101 STOP, 110 SET_BUS
- cmd_data_i  in  DATA_WIDTH  write byte, or bus id for SET_BUS
- rsp_valid_o  out  1  one-cycle completion pulse
- rsp_status_o  out  3  0 DONE, 1 NAK, 2 ARB_LOST, 3 ERR, 4 TIMEOUT, 5 BAD_OP
- rsp_data_o  out  DATA_WIDTH  read byte; valid with rsp_valid_o for READ_* ops, else 0
- cyc_o, stb_o, we_o  out  1  Wishbone master controls
- adr_o  out  ADDR_WIDTH  register address
- dat_o  out  DATA_WIDTH  write data
- dat_i  in  DATA_WIDTH  read data
- ack_i  in  1  Wishbone acknowledge
- irq_i  in  1  I2CMB interrupt

Behaviour:
- Reset (rst_i==0 at posedge):
  - State goes to EN_CORE; all outputs 0.
  - Timeout counter cleared; latched op and data cleared.
  - Reset mid-transaction aborts immediately; no response is issued.
- Wishbone bus cycle rule:
  - cyc_o, stb_o, adr_o, we_o and dat_o are registered.
  - They are asserted in the cycle the bus-access state is entered and held stable until ack_i is sampled high.
  - cyc_o and stb_o drop in the following cycle.
  - Minimum 2 cycles per access; zero-wait ack is accepted.
  - adr_o only ever takes values 0..3.
  - dat_o is 0 on reads.
- States:
  - EN_CORE: write CSR=0xC0 (E and IE set). On ack -> IDLE.
  - IDLE: cmd_ready_o=1, the only state where it is 1. On cmd_valid_i, latch op and data.
    - Opcode 000 or 111 -> RESP with BAD_OP; no bus access.
    - WRITE or SET_BUS -> WR_DPR.
    - All others -> WR_CMDR.
  - WR_DPR: write DPR=latched data. On ack -> WR_CMDR.
  - WR_CMDR: write CMDR={5'b0, op}. On ack -> WAIT_IRQ with counter cleared.
  - WAIT_IRQ:
    - irq_i==1 -> RD_CMDR.
    - Otherwise the counter increments; at IRQ_TIMEOUT-1 -> RESP with TIMEOUT and no CMDR read.
    - irq_i already high on the first WAIT_IRQ cycle is accepted.
  - RD_CMDR: read CMDR and capture dat_i at ack. Status priority: bit4 ERR > bit5 AL > bit6 NAK > bit7 DON -> DONE. If no status bit is set -> ERR.
    - Reserved bit3 set also forces ERR.
    - If a READ_* op ends in DONE -> RD_DPR; otherwise -> RESP.
  - RD_DPR: read DPR, capture into rsp_data. On ack -> RESP.
  - RESP: rsp_valid_o=1 for exactly one cycle -> IDLE.
- rsp_status_o and rsp_data_o hold their values until the next RESP.
- irq_i asserting outside WAIT_IRQ is ignored.
- A new cmd_valid_i during a busy period is not consumed; the client holds it.
- Command-to-response latency with zero-wait slave and immediate IRQ:
  - WRITE / SET_BUS: 7 cycles.
  - START / STOP: 5 cycles.
  - READ_*: 7 cycles.
- Exact latencies are documented in the test plan via the zero-wait model.

Decomposition:
- i2cmb_env_pkg gains:
  - Register address localparams CSR_ADDR, DPR_ADDR, CMDR_ADDR, FSMR_ADDR.
  - CSR_ENABLE_VAL=8'hC0.
  - Enum i2c_op_t (3-bit CMDR codes).
  - Enum seq_status_t.
  - Enum seq_state_t.
  - CMDR bit-position localparams (DON, NAK, AL, ERR, R).
- One sub-module: i2cmb_wb_xfer, a single-access Wishbone master.
  - Handshake: req, we, adr, wdata in; done pulse with rdata out.
  - The sequencer FSM only issues xfer requests.

Test Plan:
- Reset release -> one write adr_o=0, dat_o=0xC0; then cmd_ready_o=1 and no further bus activity.
- SET_BUS data 0x05, slave acks, irq after 10 cycles, CMDR read returns 0x80 -> bus writes DPR=0x05, CMDR=0x06, then CMDR read; rsp DONE; irq cleared the cycle after the read.
- WRITE 0xA5 with CMDR read returning 0x40 -> rsp NAK, rsp_data 0, no DPR read.
- READ_NAK with CMDR 0x80 and DPR 0x3C -> rsp DONE, rsp_data 0x3C; bus access order CMDR wr, CMDR rd, DPR rd.
- START with irq never asserted (IRQ_TIMEOUT=16) -> TIMEOUT after exactly 16 WAIT_IRQ cycles; no CMDR read; back to IDLE.
- Opcode 3'b111 -> BAD_OP pulse 2 cycles after acceptance, zero bus cycles.
- Reset asserted while in WAIT_IRQ -> cyc_o=0 next cycle, no rsp_valid_o, EN_CORE write repeats.
